// File: rtl/qqspi_arbiter.sv
// Round-robin arbiter sharing one qqspi controller between two bus requesters.
// Grant is held for a whole transaction; hung transactions are force-completed.
//
// state | meaning
// IDLE  | no owner, s_valid low, arbitration for the next grant
// BUSY0 | requester 0 owns the controller
// BUSY1 | requester 1 owns the controller
module qqspi_arbiter #(
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_valid,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    input  logic                  m0_psram,
    output logic                  m0_ready,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_valid,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    input  logic                  m1_psram,
    output logic                  m1_ready,
    output logic [31:0]           m1_rdata,

    output logic                  s_valid,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    output logic                  s_psram,
    input  logic                  s_ready,
    input  logic [31:0]           s_rdata,

    output logic [1:0]            grant,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last;
    logic             last_next;
    logic [CNT_W-1:0] tmr;
    logic             busy;
    logic             cur_valid;
    logic             done_ok;
    logic             done_tmo;
    logic             abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            last        <= 1'b1;
            tmr         <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            last  <= last_next;
            grant <= {state_next == BUSY1, state_next == BUSY0};
            if (done_tmo) begin
                timeout_err <= 1'b1;
            end
            // Down-counter: loaded on grant, terminal count marks the last allowed cycle.
            if (!busy && state_next != IDLE) begin
                tmr <= TMR_LOAD;
            end else if (busy && tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        cur_valid = 1'b0;
        if (state == BUSY0) begin
            cur_valid = m0_valid;
        end else if (state == BUSY1) begin
            cur_valid = m1_valid;
        end
        // s_ready beats a coincident timeout; a dropped request aborts quietly.
        done_ok  = busy && s_ready;
        abort    = busy && !s_ready && !cur_valid;
        done_tmo = busy && !s_ready && cur_valid && (tmr == '0);
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_next = last ? BUSY0 : BUSY1;
                end else if (m0_valid) begin
                    state_next = BUSY0;
                end else if (m1_valid) begin
                    state_next = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (done_ok || done_tmo) begin
                    state_next = IDLE;
                    last_next  = (state == BUSY1);
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = 32'h0;
        s_wstrb  = 4'h0;
        s_psram  = 1'b0;
        m0_ready = 1'b0;
        m0_rdata = 32'h0;
        m1_ready = 1'b0;
        m1_rdata = 32'h0;
        if (state == BUSY0) begin
            s_valid  = m0_valid && !done_tmo;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            s_psram  = m0_psram;
            m0_ready = done_ok || done_tmo;
            m0_rdata = done_ok ? s_rdata : 32'h0;
        end else if (state == BUSY1) begin
            s_valid  = m1_valid && !done_tmo;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            s_psram  = m1_psram;
            m1_ready = done_ok || done_tmo;
            m1_rdata = done_ok ? s_rdata : 32'h0;
        end
    end

endmodule
